// File: rtl/match_event_logger.sv
// match_event_logger: timestamps rising edges of the detector match flag F and queues
// {ts, previous state} entries in a small FIFO drained over valid/ready. Rev 1.0
`default_nettype none

module match_event_logger #(
  parameter int TS_WIDTH  = 8,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     F,
  input  logic [2:0]               S,
  input  logic                     en,
  input  logic                     clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TS_WIDTH-1:0]      out_ts,
  output logic [2:0]               out_prev,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_WIDTH-1:0]     evt_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [TS_WIDTH-1:0] ts;
  logic                f_d;
  logic [2:0]          s_d;
  logic [TS_WIDTH+2:0] mem [DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic                evt;
  logic                pop;
  logic                push;
  logic                empty;
  logic                full;

  // Pointers carry one extra bit so their difference spans 0..DEPTH.
  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (level == FULL_LEVEL);

  assign evt  = F & ~f_d & en & ~clr;
  assign pop  = ~empty & out_ready & ~clr;
  assign push = evt & (~full | pop);

  assign out_valid = ~empty;

  always_comb begin
    out_ts   = '0;
    out_prev = '0;
    if (!empty) begin
      {out_ts, out_prev} = mem[rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ts        <= '0;
      f_d       <= 1'b0;
      s_d       <= 3'b000;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      f_d <= F;
      s_d <= S;
      if (clr) begin
        ts        <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        evt_count <= '0;
        overflow  <= 1'b0;
      end else begin
        ts <= ts + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (evt && (evt_count != '1)) evt_count <= evt_count + 1'b1;
        if (evt && !push) overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the empty mux hides stale contents.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {ts, s_d};
  end

endmodule

`default_nettype wire
